coeff_receiver: RTL and testbench

- Responder end of the coefficient-load handshake; sits inside the FIR filter datapath, opposite the coefficient loader.
- Captures one coefficient word per `load_coeff` request into an indexed register bank, and acknowledges by holding `modwait` high for a fixed write latency.
- Reports when a full set has been received and drives the coefficient bank to the MAC datapath.

---
 rtl/coeff_receiver_pkg.sv | 13 +
 rtl/coeff_receiver_if.sv | 13 +
 rtl/coeff_receiver_modwait_timer.sv | 23 ++
 rtl/coeff_receiver.sv | 121 ++++++++++++
 tb/tb_coeff_receiver.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/coeff_receiver_pkg.sv
// Shared types and default sizes for the coefficient receiver.
package coeff_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_NUM_COEFF = 4;

endpackage

// File: rtl/coeff_receiver_if.sv
// Coefficient-load handshake between the loader (master) and the receiver (slave).
interface coeff_receiver_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 2
);
    logic              load_coeff;
    logic [IDX_W-1:0]  coefficient_num;
    logic [DATA_W-1:0] coeff_in;
    logic              modwait;

    modport master (output load_coeff, coefficient_num, coeff_in, input modwait);
    modport slave  (input load_coeff, coefficient_num, coeff_in, output modwait);
endinterface

// File: rtl/coeff_receiver_modwait_timer.sv
// Loadable down-counter that times how long modwait stays high; last flags count == 1.
module modwait_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign last = (count == CNT_W'(1));
endmodule

// File: rtl/coeff_receiver.sv
// Coefficient receiver: captures indexed words into a bank and acknowledges with modwait.
// Define COEFF_SHADOW_EN to drive coeff_out from a shadow bank updated once per complete set.
//
// state   | meaning
// IDLE    | ready; load_coeff captures a word
// HOLD    | modwait high while the write latency runs down
// RELEASE | one low cycle of modwait before re-arming
module coeff_receiver
    import coeff_rx_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_COEFF   = DEF_NUM_COEFF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    coeff_receiver_if.slave             bus,
    output logic [NUM_COEFF*DATA_W-1:0] coeff_out,
    output logic                        coeff_valid,
    output logic                        set_done,
    output logic                        proto_err
);
    localparam int IDX_W = $clog2(NUM_COEFF);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(NUM_COEFF);

    state_t                      state, state_nxt;
    logic                        capture;
    logic                        cnt_last;
    logic                        idx_ok;
    logic                        set_complete;
    logic [NUM_COEFF-1:0]        mask, mask_nxt;
    logic [DATA_W-1:0]           coeff_reg [NUM_COEFF];
    logic [NUM_COEFF*DATA_W-1:0] bank_flat;

    assign idx_ok       = ({1'b0, bus.coefficient_num} < IDX_LIMIT);
    assign set_complete = (&mask) & ~coeff_valid;

    modwait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bus.modwait <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus.modwait <= (state_nxt == HOLD);
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_coeff) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD:    if (cnt_last) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An index-0 capture starts a new set, so it wipes the mask before marking itself.
    always_comb begin
        mask_nxt = mask;
        if (capture && idx_ok) begin
            if (bus.coefficient_num == '0)
                mask_nxt = '0;
            mask_nxt[bus.coefficient_num] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_COEFF; k++)
                coeff_reg[k] <= '0;
            mask        <= '0;
            coeff_valid <= 1'b0;
            set_done    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (capture && idx_ok)
                coeff_reg[bus.coefficient_num] <= bus.coeff_in;
            mask        <= mask_nxt;
            coeff_valid <= &mask;
            set_done    <= set_complete;
            if ((state == HOLD && bus.load_coeff) || (capture && !idx_ok))
                proto_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_COEFF; g++) begin : g_flat
        assign bank_flat[g*DATA_W +: DATA_W] = coeff_reg[g];
    end

`ifdef COEFF_SHADOW_EN
    logic [NUM_COEFF*DATA_W-1:0] shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (set_complete)
            shadow <= bank_flat;
    end

    assign coeff_out = shadow;
`else
    assign coeff_out = bank_flat;
`endif

endmodule

// File: tb/tb_coeff_receiver.sv
// Directed self-checking bench for coeff_receiver (WAIT_CYCLES=2, NUM_COEFF=4, DATA_W=16).
module tb_coeff_receiver;
    logic        clk;
    logic        reset;
    logic [63:0] coeff_out;
    logic        coeff_valid;
    logic        set_done;
    logic        proto_err;
    int          n_checks;
    int          n_errors;
    int          sd_count;

    coeff_receiver_if #(.DATA_W(16), .IDX_W(2)) bus ();

    coeff_receiver #(.DATA_W(16), .NUM_COEFF(4), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .coeff_out   (coeff_out),
        .coeff_valid (coeff_valid),
        .set_done    (set_done),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (set_done) sd_count++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge of the first IDLE cycle afterwards.
    task automatic capture(input logic [1:0] idx, input logic [15:0] data, input string tag);
        bus.load_coeff      = 1'b1;
        bus.coefficient_num = idx;
        bus.coeff_in        = data;
        @(negedge clk);
        bus.load_coeff = 1'b0;
        chk({tag, "_mw1"}, 64'(bus.modwait), 64'd1);
        @(negedge clk);
        chk({tag, "_mw2"}, 64'(bus.modwait), 64'd1);
        @(negedge clk);
        chk({tag, "_mw_rel"}, 64'(bus.modwait), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sd_count = 0;
        reset = 1'b1;
        bus.load_coeff      = 1'b0;
        bus.coefficient_num = 2'd0;
        bus.coeff_in        = 16'h0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_modwait", 64'(bus.modwait), 64'd0);
        chk("rst_coeff_out", coeff_out, 64'd0);
        chk("rst_valid", 64'(coeff_valid), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);

        // Single capture to index 2
        capture(2'd2, 16'h1234, "single");
`ifdef COEFF_SHADOW_EN
        chk("single_out", coeff_out, 64'd0);
`else
        chk("single_out", coeff_out, 64'h0000_1234_0000_0000);
`endif
        chk("single_valid", 64'(coeff_valid), 64'd0);
        chk("single_sd", 64'(sd_count), 64'd0);

        // Full in-order set
        capture(2'd0, 16'h0001, "set_i0");
        capture(2'd1, 16'h0002, "set_i1");
        capture(2'd2, 16'h0003, "set_i2");
        chk("set_valid_early", 64'(coeff_valid), 64'd0);
        capture(2'd3, 16'h0004, "set_i3");
        repeat (3) @(negedge clk);
        chk("set_sd_count", 64'(sd_count), 64'd1);
        chk("set_valid", 64'(coeff_valid), 64'd1);
        chk("set_out", coeff_out, 64'h0004_0003_0002_0001);

        // New set restart: valid drops the cycle after the index-0 capture
        bus.load_coeff      = 1'b1;
        bus.coefficient_num = 2'd0;
        bus.coeff_in        = 16'hAAAA;
        @(negedge clk);
        bus.load_coeff = 1'b0;
        chk("restart_valid_hold", 64'(coeff_valid), 64'd1);
        @(negedge clk);
        chk("restart_valid_drop", 64'(coeff_valid), 64'd0);
        repeat (2) @(negedge clk);
`ifdef COEFF_SHADOW_EN
        chk("restart_out", coeff_out, 64'h0004_0003_0002_0001);
`else
        chk("restart_out", coeff_out, 64'h0004_0003_0002_AAAA);
`endif
        capture(2'd3, 16'h0007, "restart_i3");
        capture(2'd1, 16'h0005, "restart_i1");
`ifdef COEFF_SHADOW_EN
        chk("restart_out_partial", coeff_out, 64'h0004_0003_0002_0001);
`else
        chk("restart_out_partial", coeff_out, 64'h0007_0003_0005_AAAA);
`endif
        capture(2'd2, 16'h0006, "restart_i2");
        repeat (2) @(negedge clk);
        chk("restart_out_full", coeff_out, 64'h0007_0006_0005_AAAA);
        chk("restart_sd_count", 64'(sd_count), 64'd2);
        chk("restart_valid", 64'(coeff_valid), 64'd1);
        chk("pre_proto", 64'(proto_err), 64'd0);

        // Protocol violation: load_coeff held through HOLD with changing data
        bus.load_coeff      = 1'b1;
        bus.coefficient_num = 2'd1;
        bus.coeff_in        = 16'h1111;
        @(negedge clk);
        bus.coeff_in = 16'h2222;
        chk("viol_mw", 64'(bus.modwait), 64'd1);
        @(negedge clk);
        bus.coeff_in = 16'h3333;
        chk("viol_proto", 64'(proto_err), 64'd1);
        @(negedge clk);
        bus.load_coeff = 1'b0;
        chk("viol_mw_rel", 64'(bus.modwait), 64'd0);
        repeat (4) @(negedge clk);
`ifdef COEFF_SHADOW_EN
        chk("viol_out", coeff_out, 64'h0007_0006_0005_AAAA);
`else
        chk("viol_out", coeff_out, 64'h0007_0006_1111_AAAA);
`endif
        chk("viol_proto_sticky", 64'(proto_err), 64'd1);
        chk("viol_valid", 64'(coeff_valid), 64'd1);

        // Async reset mid-HOLD, sampled between clock edges
        bus.load_coeff      = 1'b1;
        bus.coefficient_num = 2'd2;
        bus.coeff_in        = 16'h5555;
        @(negedge clk);
        bus.load_coeff = 1'b0;
        chk("arst_mw_before", 64'(bus.modwait), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_mw", 64'(bus.modwait), 64'd0);
        chk("arst_out", coeff_out, 64'd0);
        chk("arst_valid", 64'(coeff_valid), 64'd0);
        chk("arst_proto", 64'(proto_err), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Mask was cleared: three words without index 0 must not complete a set
        @(negedge clk);
        capture(2'd1, 16'h0101, "post_i1");
        capture(2'd2, 16'h0202, "post_i2");
        capture(2'd3, 16'h0303, "post_i3");
        repeat (2) @(negedge clk);
        chk("post_valid", 64'(coeff_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
